// File: rtl/program_sequencer_stacked_pkg.sv
// Shared types and helpers for the stacked program sequencer.
// Defines the next-pc source selector and a constant-foldable clog2.
package program_sequencer_stacked_pkg;

   typedef enum logic [1:0] {
      SRC_SEQ,
      SRC_JMP,
      SRC_STACK,
      SRC_IRQ
   } pc_src_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/program_sequencer_stacked_return_stack.sv
// Level-counter based LIFO of return addresses.
// A push onto a full stack or a pop from an empty one is refused and flagged for one cycle.
module program_sequencer_stacked_return_stack
   import program_sequencer_stacked_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   localparam int LVL_W = clog2(DEPTH) + 1,
   localparam int IDX_W = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     push_data,
   output logic [W-1:0]     top,
   output logic [LVL_W-1:0] level,
   output logic             overflow,
   output logic             underflow
);

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [LVL_W-1:0] level_q, level_d;
   logic [IDX_W-1:0] wr_idx, top_idx;
   logic             full, empty;

   assign full    = (level_q == LVL_W'(DEPTH));
   assign empty   = (level_q == '0);
   assign wr_idx  = level_q[IDX_W-1:0];
   // Wraps when empty; the read is unused then because the pop is refused.
   assign top_idx = IDX_W'(level_q - LVL_W'(1));
   assign top     = mem_q[top_idx];
   assign level   = level_q;

   always_comb begin
      mem_d     = mem_q;
      level_d   = level_q;
      overflow  = 1'b0;
      underflow = 1'b0;
      if (push) begin
         if (full) begin
            overflow = 1'b1;
         end else begin
            mem_d[wr_idx] = push_data;
            level_d       = level_q + LVL_W'(1);
         end
      end else if (pop) begin
         if (empty) begin
            underflow = 1'b1;
         end else begin
            level_d = level_q - LVL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         level_q <= '0;
      end else begin
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/program_sequencer_stacked.sv
// Program sequencer: registered pc with prioritised jump/call/return/interrupt selection,
// wait-state stalls via pm_ready, and a hardware return-address stack.
module program_sequencer_stacked
   import program_sequencer_stacked_pkg::*;
#(
   parameter int                   PM_ADDR_W    = 8,
   parameter int                   STACK_DEPTH  = 4,
   parameter logic [PM_ADDR_W-1:0] RESET_VECTOR = '0,
   parameter logic [PM_ADDR_W-1:0] IRQ_VECTOR   = PM_ADDR_W'(8'hF0),
   localparam int                  LVL_W        = clog2(STACK_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 pm_ready,
   input  logic                 jmp,
   input  logic                 jmp_nz,
   input  logic                 dont_jmp,
   input  logic                 call,
   input  logic                 ret,
   input  logic                 reti,
   input  logic [PM_ADDR_W-1:0] jmp_addr,
   input  logic                 irq,
   input  logic                 irq_en,
   output logic [PM_ADDR_W-1:0] pm_addr,
   output logic                 irq_ack,
   output logic                 in_isr,
   output logic [LVL_W-1:0]     stack_level,
   output logic                 stack_err
);

   logic [PM_ADDR_W-1:0] pc_q, pc_d, pc_inc, stack_top;
   logic                 in_isr_q, in_isr_d;
   logic                 pend_q, pend_d;
   logic                 ack_q, ack_d;
   logic                 err_q, err_d;
   logic                 push, pop, take;
   logic                 overflow, underflow;
   pc_src_e              src;

   assign pc_inc = pc_q + PM_ADDR_W'(1);

   program_sequencer_stacked_return_stack #(
      .W     (PM_ADDR_W),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .pop       (pop),
      .push_data (pc_inc),
      .top       (stack_top),
      .level     (stack_level),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always_comb begin
      src      = SRC_SEQ;
      push     = 1'b0;
      pop      = 1'b0;
      take     = 1'b0;
      in_isr_d = in_isr_q;
      ack_d    = 1'b0;
      pc_d     = pc_q;
      if (pm_ready) begin
         // A suppressed jmp_nz still counts as a strobe and blocks call/interrupt.
         if (reti) begin
            src      = SRC_STACK;
            pop      = 1'b1;
            in_isr_d = 1'b0;
         end else if (ret) begin
            src = SRC_STACK;
            pop = 1'b1;
         end else if (jmp) begin
            src = SRC_JMP;
         end else if (jmp_nz) begin
            src = dont_jmp ? SRC_SEQ : SRC_JMP;
         end else if (call) begin
            src  = SRC_JMP;
            push = 1'b1;
         end else if (pend_q && irq_en && !in_isr_q) begin
            src      = SRC_IRQ;
            push     = 1'b1;
            take     = 1'b1;
            in_isr_d = 1'b1;
            ack_d    = 1'b1;
         end
         case (src)
            SRC_SEQ:   pc_d = pc_inc;
            SRC_JMP:   pc_d = jmp_addr;
            SRC_STACK: pc_d = underflow ? pc_inc : stack_top;
            SRC_IRQ:   pc_d = IRQ_VECTOR;
            default:   pc_d = pc_inc;
         endcase
      end
      // A request arriving on the take cycle stays latched for the next opportunity.
      pend_d = (pend_q & ~take) | irq;
      err_d  = err_q | overflow | underflow;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc_q     <= RESET_VECTOR;
         in_isr_q <= 1'b0;
         pend_q   <= 1'b0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         in_isr_q <= in_isr_d;
         pend_q   <= pend_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
      end
   end

   assign pm_addr   = pc_q;
   assign irq_ack   = ack_q;
   assign in_isr    = in_isr_q;
   assign stack_err = err_q;

endmodule

// File: tb/tb_program_sequencer_stacked.sv
// Self-checking bench for program_sequencer_stacked: directed scenarios plus a random run,
// all compared against a queue-based behavioural model of the sequencer.
module tb_program_sequencer_stacked;

   localparam int PW    = 8;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;
   localparam int VW    = PW + LW + 3;
   localparam int IRQV  = 'hF0;
   localparam int MASK  = (1 << PW) - 1;

   logic          clk;
   logic          reset_n, pm_ready, jmp, jmp_nz, dont_jmp, call, ret, reti, irq, irq_en;
   logic [PW-1:0] jmp_addr;
   logic [PW-1:0] pm_addr;
   logic          irq_ack, in_isr, stack_err;
   logic [LW-1:0] stack_level;
   logic [VW-1:0] dut_vec;

   int n_tests = 0;
   int n_fail  = 0;

   int m_pc;
   int m_stack[$];
   bit m_err, m_isr, m_pend, m_ack;

   program_sequencer_stacked dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .pm_ready    (pm_ready),
      .jmp         (jmp),
      .jmp_nz      (jmp_nz),
      .dont_jmp    (dont_jmp),
      .call        (call),
      .ret         (ret),
      .reti        (reti),
      .jmp_addr    (jmp_addr),
      .irq         (irq),
      .irq_en      (irq_en),
      .pm_addr     (pm_addr),
      .irq_ack     (irq_ack),
      .in_isr      (in_isr),
      .stack_level (stack_level),
      .stack_err   (stack_err)
   );

   assign dut_vec = {pm_addr, stack_level, stack_err, in_isr, irq_ack};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [VW-1:0] exp_vec();
      return {PW'(m_pc), LW'(m_stack.size()), m_err, m_isr, m_ack};
   endfunction

   function automatic void model_push(input int addr);
      if (m_stack.size() == DEPTH) m_err = 1'b1;
      else m_stack.push_back(addr & MASK);
   endfunction

   // Behavioural model of one rising edge, evaluated from the inputs present at that edge.
   function automatic void model_step();
      bit take;
      take = 1'b0;
      if (!reset_n) begin
         m_pc = 0;
         m_stack.delete();
         m_err = 0; m_isr = 0; m_pend = 0; m_ack = 0;
         return;
      end
      m_ack = 1'b0;
      if (pm_ready) begin
         if (reti || ret) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin
               m_pc  = (m_pc + 1) & MASK;
               m_err = 1'b1;
            end
            if (reti) m_isr = 1'b0;
         end else if (jmp) begin
            m_pc = jmp_addr;
         end else if (jmp_nz) begin
            m_pc = dont_jmp ? ((m_pc + 1) & MASK) : int'(jmp_addr);
         end else if (call) begin
            model_push(m_pc + 1);
            m_pc = jmp_addr;
         end else if (m_pend && irq_en && !m_isr) begin
            model_push(m_pc + 1);
            m_pc  = IRQV;
            m_isr = 1'b1;
            m_ack = 1'b1;
            take  = 1'b1;
         end else begin
            m_pc = (m_pc + 1) & MASK;
         end
      end
      m_pend = (m_pend && !take) || irq;
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_idle();
      jmp = 0; jmp_nz = 0; dont_jmp = 0; call = 0; ret = 0; reti = 0; irq = 0;
      jmp_addr = '0;
   endtask

   task automatic test_reset();
      reset_n = 0; pm_ready = 1; irq_en = 0; set_idle();
      cycle(); cycle();
      n_tests++;
      if (dut_vec !== exp_vec() || pm_addr !== 8'h00 || stack_level !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got %h exp %h", dut_vec, exp_vec());
      end
      reset_n = 1;
      for (int i = 1; i <= 3; i++) begin
         cycle();
         n_tests++;
         if (dut_vec !== exp_vec() || pm_addr !== PW'(i) || irq_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_run step %0d: got %h exp %h", i, dut_vec, exp_vec());
         end
      end
   endtask

   task automatic test_jumps();
      jmp = 1; jmp_addr = 8'h05; cycle(); jmp = 0;
      jmp_nz = 1; dont_jmp = 1; jmp_addr = 8'h77; cycle();
      n_tests++;
      if (dut_vec !== exp_vec() || pm_addr !== 8'h06) begin
         n_fail++;
         $display("FAIL jmp_nz_suppressed: got %h exp %h", dut_vec, exp_vec());
      end
      dont_jmp = 0; jmp_addr = 8'h40; cycle(); jmp_nz = 0;
      n_tests++;
      if (dut_vec !== exp_vec() || pm_addr !== 8'h40) begin
         n_fail++;
         $display("FAIL jmp_nz_taken: got %h exp %h", dut_vec, exp_vec());
      end
      jmp = 1; jmp_addr = 8'hFF; cycle(); jmp = 0; cycle();
      n_tests++;
      if (dut_vec !== exp_vec() || pm_addr !== 8'h00) begin
         n_fail++;
         $display("FAIL pc_wrap: got %h exp %h", dut_vec, exp_vec());
      end
      pm_ready = 0; jmp = 1; jmp_addr = 8'h99; cycle(); cycle();
      n_tests++;
      if (dut_vec !== exp_vec() || pm_addr !== 8'h00) begin
         n_fail++;
         $display("FAIL stall_hold: got %h exp %h", dut_vec, exp_vec());
      end
      pm_ready = 1; jmp = 0;
   endtask

   task automatic test_call_ret();
      jmp = 1; jmp_addr = 8'h10; cycle(); jmp = 0;
      call = 1; jmp_addr = 8'h80; cycle(); call = 0;
      n_tests++;
      if (dut_vec !== exp_vec() || pm_addr !== 8'h80 || stack_level !== LW'(1)) begin
         n_fail++;
         $display("FAIL call: got %h exp %h", dut_vec, exp_vec());
      end
      ret = 1; cycle(); ret = 0;
      n_tests++;
      if (dut_vec !== exp_vec() || pm_addr !== 8'h11 || stack_level !== LW'(0)) begin
         n_fail++;
         $display("FAIL ret: got %h exp %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_stack_overflow();
      int exp_ret [5] = '{'h51, 'h41, 'h31, 'h12, 'h13};
      jmp = 1; jmp_addr = 8'h11; cycle(); jmp = 0;
      for (int i = 0; i < 5; i++) begin
         call = 1; jmp_addr = PW'(8'h30 + 8'h10 * i); cycle();
      end
      call = 0;
      n_tests++;
      if (dut_vec !== exp_vec() || pm_addr !== 8'h70 || stack_level !== LW'(4) || stack_err !== 1'b1) begin
         n_fail++;
         $display("FAIL overflow: got %h exp %h", dut_vec, exp_vec());
      end
      for (int i = 0; i < 5; i++) begin
         ret = 1; cycle();
         n_tests++;
         if (dut_vec !== exp_vec() || pm_addr !== PW'(exp_ret[i])) begin
            n_fail++;
            $display("FAIL pop %0d: got %h exp %h", i, dut_vec, exp_vec());
         end
      end
      ret = 0;
   endtask

   task automatic test_interrupt();
      reset_n = 0; cycle(); reset_n = 1;
      jmp = 1; jmp_addr = 8'h20; cycle(); jmp = 0;
      pm_ready = 0; irq = 1; cycle(); irq = 0; cycle();
      n_tests++;
      if (dut_vec !== exp_vec() || pm_addr !== 8'h20 || irq_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_stall: got %h exp %h", dut_vec, exp_vec());
      end
      pm_ready = 1; irq_en = 1; cycle();
      n_tests++;
      if (dut_vec !== exp_vec() || pm_addr !== PW'(IRQV) || irq_ack !== 1'b1 || in_isr !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_take: got %h exp %h", dut_vec, exp_vec());
      end
      irq = 1; cycle(); irq = 0; cycle();
      n_tests++;
      if (dut_vec !== exp_vec() || pm_addr !== 8'hF2 || irq_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_nested_deferred: got %h exp %h", dut_vec, exp_vec());
      end
      reti = 1; cycle(); reti = 0;
      n_tests++;
      if (dut_vec !== exp_vec() || pm_addr !== 8'h21 || in_isr !== 1'b0) begin
         n_fail++;
         $display("FAIL reti: got %h exp %h", dut_vec, exp_vec());
      end
      cycle();
      n_tests++;
      if (dut_vec !== exp_vec() || pm_addr !== PW'(IRQV) || irq_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_second_take: got %h exp %h", dut_vec, exp_vec());
      end
      reti = 1; cycle(); reti = 0;
      irq = 1; jmp = 1; jmp_addr = 8'h50; cycle(); irq = 0; jmp = 0;
      n_tests++;
      if (dut_vec !== exp_vec() || pm_addr !== 8'h50 || irq_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_with_jmp: got %h exp %h", dut_vec, exp_vec());
      end
      cycle();
      n_tests++;
      if (dut_vec !== exp_vec() || pm_addr !== PW'(IRQV) || irq_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_after_jmp: got %h exp %h", dut_vec, exp_vec());
      end
      reti = 1; cycle(); reti = 0;
      n_tests++;
      if (dut_vec !== exp_vec() || pm_addr !== 8'h51) begin
         n_fail++;
         $display("FAIL reti_after_jmp: got %h exp %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_reset_mid_isr();
      irq = 1; cycle(); irq = 0; cycle();
      call = 1; jmp_addr = 8'h90; cycle(); call = 0;
      irq = 1; cycle(); irq = 0;
      n_tests++;
      if (dut_vec !== exp_vec() || in_isr !== 1'b1 || stack_level !== LW'(2)) begin
         n_fail++;
         $display("FAIL isr_setup: got %h exp %h", dut_vec, exp_vec());
      end
      reset_n = 0; cycle(); reset_n = 1;
      n_tests++;
      if (dut_vec !== exp_vec() || pm_addr !== 8'h00 || in_isr !== 1'b0 || stack_level !== LW'(0)) begin
         n_fail++;
         $display("FAIL reset_mid_isr: got %h exp %h", dut_vec, exp_vec());
      end
      cycle();
      n_tests++;
      if (dut_vec !== exp_vec() || pm_addr !== 8'h01 || irq_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL pending_cleared: got %h exp %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_random();
      reset_n = 0; cycle(); reset_n = 1;
      for (int i = 0; i < 600; i++) begin
         reset_n  = ($urandom_range(0, 99) != 0);
         pm_ready = ($urandom_range(0, 3) != 0);
         jmp      = ($urandom_range(0, 9) == 0);
         jmp_nz   = ($urandom_range(0, 9) == 0);
         dont_jmp = $urandom_range(0, 1);
         call     = ($urandom_range(0, 5) == 0);
         ret      = ($urandom_range(0, 7) == 0);
         reti     = ($urandom_range(0, 9) == 0);
         irq      = ($urandom_range(0, 9) == 0);
         irq_en   = ($urandom_range(0, 9) < 7);
         jmp_addr = PW'($urandom);
         cycle();
         n_tests++;
         if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL random cycle %0d: got %h exp %h", i, dut_vec, exp_vec());
         end
      end
      reset_n = 1; set_idle();
   endtask

   initial begin
      reset_n = 0; pm_ready = 0; irq_en = 0;
      set_idle();
      m_pc = 0; m_err = 0; m_isr = 0; m_pend = 0; m_ack = 0;
      test_reset();
      test_jumps();
      test_call_ret();
      test_stack_overflow();
      test_interrupt();
      test_reset_mid_isr();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
